// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM states and op-class helpers for the iterative
// multiply/divide unit.
package muldiv_unit_pkg;

   typedef enum logic [4:0] {
      ALU_MUL    = 5'd10,
      ALU_MULH   = 5'd11,
      ALU_MULHSU = 5'd12,
      ALU_MULHU  = 5'd13,
      ALU_DIV    = 5'd14,
      ALU_DIVU   = 5'd15,
      ALU_REM    = 5'd16,
      ALU_REMU   = 5'd17
   } alu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE,
      MDU_CALC,
      MDU_FIX,
      MDU_DONE
   } mdu_state_e;

   // Codes outside the multiply/divide group execute as MUL.
   function automatic alu_op_e op_decode(input logic [4:0] code);
      if (code >= ALU_MUL && code <= ALU_REMU) return alu_op_e'(code);
      return ALU_MUL;
   endfunction

   function automatic logic op_is_div(input alu_op_e op);
      return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

   function automatic logic op_is_rem(input alu_op_e op);
      return op inside {ALU_REM, ALU_REMU};
   endfunction

   function automatic logic op_a_signed(input alu_op_e op);
      return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
   endfunction

   function automatic logic op_b_signed(input alu_op_e op);
      return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
   endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// Combinational restoring divide step: BPC cascaded subtract-shift stages,
// most significant dividend bit consumed first.
module div_step #(
   parameter int XLEN = 32,
   parameter int BPC  = 1
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_div,
   input  logic [BPC-1:0]  i_bits,
   output logic [XLEN-1:0] o_rem,
   output logic [BPC-1:0]  o_q
);

   logic [XLEN:0]   w_t;
   logic [XLEN-1:0] w_rem;

   always_comb begin
      w_t   = '0;
      w_rem = i_rem;
      o_q   = '0;
      for (int unsigned i = 0; i < BPC; i++) begin
         w_t = {w_rem, i_bits[BPC-1-i]};
         if (w_t >= {1'b0, i_div}) begin
            w_t            = w_t - {1'b0, i_div};
            o_q[BPC-1-i]   = 1'b1;
         end
         w_rem = w_t[XLEN-1:0];
      end
      o_rem = w_rem;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: unsigned-magnitude core with
// a one-cycle sign fix-up, tag pass-through and flush.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int TAG_W          = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e       r_state, w_next;
   alu_op_e          r_op, w_op;
   logic             r_neg, r_special;
   logic [XLEN-1:0]  r_hi, r_lo, r_b, r_result;
   logic [TAG_W-1:0] r_tag;
   logic [CW-1:0]    r_cnt;

   logic              w_accept, w_sa, w_sb, w_neg, w_special;
   logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_res;
   logic [XLEN-1:0]   w_mhi, w_mlo, w_dhi, w_fix_res;
   logic [BITS_PER_CYCLE-1:0] w_dq;
   logic [XLEN:0]     w_sum;
   logic [2*XLEN-1:0] w_prod_s;

   assign w_op     = op_decode(in_op);
   assign in_ready = (r_state == MDU_IDLE);
   assign w_accept = in_valid & in_ready & ~kill;

   // REM's sign follows the dividend only; every other op uses sign(a)^sign(b),
   // which already collapses to sign(a) for MULHSU and to 0 for unsigned ops.
   always_comb begin
      w_sa       = op_a_signed(w_op) & in_a[XLEN-1];
      w_sb       = op_b_signed(w_op) & in_b[XLEN-1];
      w_mag_a    = w_sa ? -in_a : in_a;
      w_mag_b    = w_sb ? -in_b : in_b;
      w_neg      = (w_op == ALU_REM) ? w_sa : (w_sa ^ w_sb);
      w_special  = 1'b0;
      w_spec_res = '0;
      if (op_is_div(w_op)) begin
         if (in_b == '0) begin
            w_special  = 1'b1;
            w_spec_res = op_is_rem(w_op) ? in_a : '1;
         end else if (op_a_signed(w_op) && in_a == MOST_NEG && in_b == '1) begin
            w_special  = 1'b1;
            w_spec_res = op_is_rem(w_op) ? '0 : in_a;
         end
      end
   end

   // {r_hi, r_lo} is the product register; the multiplier drains out of r_lo.
   always_comb begin
      w_mhi = r_hi;
      w_mlo = r_lo;
      w_sum = '0;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         w_sum = {1'b0, w_mhi} + (w_mlo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
         w_mlo = {w_sum[0], w_mlo[XLEN-1:1]};
         w_mhi = w_sum[XLEN:1];
      end
   end

   div_step #(.XLEN(XLEN), .BPC(BITS_PER_CYCLE)) u_div_step (
      .i_rem  (r_hi),
      .i_div  (r_b),
      .i_bits (r_lo[XLEN-1 -: BITS_PER_CYCLE]),
      .o_rem  (w_dhi),
      .o_q    (w_dq)
   );

   always_comb begin
      w_prod_s = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
      if (op_is_div(r_op))
         w_fix_res = op_is_rem(r_op) ? (r_neg ? -r_hi : r_hi) : (r_neg ? -r_lo : r_lo);
      else if (r_op == ALU_MUL)
         w_fix_res = w_prod_s[XLEN-1:0];
      else
         w_fix_res = w_prod_s[2*XLEN-1:XLEN];
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         MDU_IDLE: if (w_accept) w_next = w_special ? MDU_FIX : MDU_CALC;
         MDU_CALC: if (r_cnt == CW'(1)) w_next = MDU_FIX;
         MDU_FIX:  w_next = MDU_DONE;
         MDU_DONE: if (out_ready) w_next = MDU_IDLE;
         default:  w_next = MDU_IDLE;
      endcase
      if (kill) w_next = MDU_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= MDU_IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op      <= ALU_MUL;
         r_neg     <= 1'b0;
         r_special <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_b       <= '0;
         r_result  <= '0;
         r_tag     <= '0;
         r_cnt     <= '0;
      end else if (!kill) begin
         if (w_accept) begin
            r_op      <= w_op;
            r_neg     <= w_neg;
            r_special <= w_special;
            r_hi      <= '0;
            r_lo      <= w_mag_a;
            r_b       <= w_mag_b;
            r_tag     <= in_tag;
            r_cnt     <= CW'(N);
            if (w_special) r_result <= w_spec_res;
         end else if (r_state == MDU_CALC) begin
            r_hi  <= op_is_div(r_op) ? w_dhi : w_mhi;
            r_lo  <= op_is_div(r_op) ? {r_lo[XLEN-BITS_PER_CYCLE-1:0], w_dq} : w_mlo;
            r_cnt <= r_cnt - CW'(1);
         end else if (r_state == MDU_FIX && !r_special) begin
            r_result <= w_fix_res;
         end
      end
   end

   assign out_valid  = (r_state == MDU_DONE);
   assign out_result = r_result;
   assign out_tag    = r_tag;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench: one-cycle-per-bit and four-bits-per-cycle units driven in
// lockstep, checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int unsigned acc;
      int unsigned lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        kill = 1'b0;
   logic [4:0]  in_op = '0;
   logic [4:0]  in_tag = '0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        in_ready [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [31:0] out_result [2];
   logic [4:0]  out_tag [2];

   exp_t        sb_q [2][$];
   exp_t        mon_e;
   bit          seen [2];
   bit          hs_prev [2];
   bit          hold = 1'b1;
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;

   muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .kill(kill),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_result(out_result[0]), .out_tag(out_tag[0]));

   muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .kill(kill),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_result(out_result[1]), .out_tag(out_tag[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired, required DUT event did not occur", name);
   endtask

   function automatic logic [31:0] model(input logic [4:0] code, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] pu;
      longint      ps;
      case (code)
         ALU_MULH:   begin ps = longint'(signed'(a)) * longint'(signed'(b)); return ps[63:32]; end
         ALU_MULHSU: begin ps = longint'(signed'(a)) * $signed({32'h0, b}); return ps[63:32]; end
         ALU_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
         ALU_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(signed'(a) / signed'(b));
         end
         ALU_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(signed'(a) % signed'(b));
         end
         ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         ALU_REMU: return (b == 0) ? a : a % b;
         default:  return a * b;
      endcase
   endfunction

   function automatic bit is_special(input logic [4:0] code, input logic [31:0] a,
                                     input logic [31:0] b);
      if (!(code inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU})) return 1'b0;
      if (b == 0) return 1'b1;
      return (code inside {ALU_DIV, ALU_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   // Called and returns at posedge+1.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      int unsigned n = 0;
      exp_t e;
      while (!(in_ready[0] && in_ready[1]) && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 2000) begin timeout("issue_ready"); return; end
      in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_op = 5'($urandom()); in_a = $urandom(); in_b = $urandom(); in_tag = 5'($urandom());
      e.res = model(op, a, b);
      e.tag = tag;
      e.acc = cyc;
      for (int d = 0; d < 2; d++) begin
         e.lat = is_special(op, a, b) ? 1 : ((d == 0) ? 33 : 9);
         sb_q[d].push_back(e);
         chk($sformatf("accepted%0d", d), 32'(in_ready[d]), 32'd0);
      end
   endtask

   task automatic drain();
      int unsigned n = 0;
      while ((sb_q[0].size() != 0 || sb_q[1].size() != 0) && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 3000) timeout("drain");
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom();
      endcase
   endfunction

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++) out_ready[d] = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   always @(negedge clk) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            if (hs_prev[d]) chk($sformatf("ready_after_hs%0d", d), 32'(in_ready[d]), 32'd1);
            hs_prev[d] = 1'b0;
            if (out_valid[d]) begin
               if (sb_q[d].size() == 0) begin
                  chk($sformatf("spurious_valid%0d", d), 32'(out_valid[d]), 32'd0);
               end else begin
                  mon_e = sb_q[d][0];
                  if (!seen[d]) begin
                     seen[d] = 1'b1;
                     chk($sformatf("latency%0d", d), cyc - mon_e.acc, mon_e.lat);
                  end
                  chk($sformatf("result%0d", d), out_result[d], mon_e.res);
                  chk($sformatf("tag%0d", d), 32'(out_tag[d]), 32'(mon_e.tag));
                  chk($sformatf("busy_in_done%0d", d), 32'(in_ready[d]), 32'd0);
                  if (out_ready[d]) begin
                     void'(sb_q[d].pop_front());
                     seen[d]    = 1'b0;
                     hs_prev[d] = 1'b1;
                  end
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_in_ready%0d", tag, d), 32'(in_ready[d]), 32'd1);
         chk($sformatf("%s_out_valid%0d", tag, d), 32'(out_valid[d]), 32'd0);
         chk($sformatf("%s_out_result%0d", tag, d), out_result[d], 32'd0);
         chk($sformatf("%s_out_tag%0d", tag, d), 32'(out_tag[d]), 32'd0);
      end
   endtask

   initial begin
      logic [4:0] ops [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                              ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      logic [4:0] op;
      int unsigned n;
      out_ready[0] = 1'b0;
      out_ready[1] = 1'b0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b1;
      @(posedge clk); #1;
      hold = 1'b0;

      issue(ALU_MUL,    32'd7,         32'hFFFF_FFFD, 5'd3);
      issue(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 5'd4);
      issue(ALU_MULHU,  32'h8000_0000, 32'h8000_0000, 5'd5);
      issue(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
      issue(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
      issue(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
      issue(ALU_DIVU,   32'd5,         32'd0,         5'd9);
      issue(ALU_REMU,   32'd5,         32'd0,         5'd10);
      issue(ALU_DIV,    32'hFFFF_FFF9, 32'd2,         5'd11);
      issue(ALU_REM,    32'hFFFF_FFF9, 32'd2,         5'd12);
      issue(ALU_REMU,   32'd100,       32'd7,         5'd13);
      issue(5'd31,      32'd12345,     32'd678,       5'd14);
      drain();

      hold = 1'b1;
      kill = 1'b1; in_valid = 1'b1; in_op = ALU_MUL; in_a = 32'd5; in_b = 32'd6;
      @(posedge clk); #1;
      kill = 1'b0; in_valid = 1'b0;
      for (int d = 0; d < 2; d++) chk($sformatf("kill_idle_ready%0d", d), 32'(in_ready[d]), 32'd1);

      issue(ALU_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, 5'd21);
      repeat (9) @(posedge clk);
      #1;
      kill = 1'b1; in_valid = 1'b1; in_op = ALU_MUL; in_a = 32'd3; in_b = 32'd4; in_tag = 5'd22;
      @(posedge clk); #1;
      kill = 1'b0; in_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("kill_ready%0d", d), 32'(in_ready[d]), 32'd1);
         chk($sformatf("kill_valid%0d", d), 32'(out_valid[d]), 32'd0);
         void'(sb_q[d].pop_back());
         seen[d] = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;
      hold = 1'b0;
      issue(ALU_MUL, 32'h0001_0003, 32'h0000_0101, 5'd23);
      drain();

      hold = 1'b1;
      issue(ALU_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 5'd24);
      n = 0;
      while (!(out_valid[0] && out_valid[1]) && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) timeout("stall_valid");
      repeat (5) @(posedge clk);
      #1;
      hold = 1'b0;
      drain();

      for (int i = 0; i < 150; i++) begin
         op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 9)) : ops[$urandom_range(0, 7)];
         issue(op, pick(), pick(), 5'($urandom()));
      end
      drain();

      hold = 1'b1;
      issue(ALU_MUL, 32'd9, 32'd9, 5'h1F);
      repeat (4) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      for (int d = 0; d < 2; d++) begin
         sb_q[d].delete();
         seen[d]    = 1'b0;
         hs_prev[d] = 1'b0;
      end
      #3 rst = 1'b1;
      @(posedge clk); #1;
      hold = 1'b0;
      issue(ALU_REM, 32'hFFFF_FF9C, 32'd7, 5'd2);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
      $fatal(1, "global timeout");
   end

endmodule
